// File: rtl/mux_pkg.sv
// Shared helpers for the pipelined mux tree: derived widths, depths and stage counts.
package mux_pkg;

   // Smallest r with 2**r >= n (0 for n <= 1)
   function automatic int unsigned clog2_ceil(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Select width: never narrower than one bit, even for a single lane
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 2) ? 1 : clog2_ceil(n);
   endfunction

   // Register stages: ceil(levels/reg_every), at least one output register
   function automatic int unsigned num_stages(input int unsigned levels,
                                              input int unsigned reg_every);
      return (levels == 0) ? 1 : (levels + reg_every - 1) / reg_every;
   endfunction

   // Lanes entering tree level 'level' for an n-lane mux: ceil(n / 2**level)
   function automatic int unsigned lanes_at(input int unsigned n,
                                            input int unsigned level);
      int unsigned r;
      r = n;
      for (int unsigned k = 0; k < level; k++) begin
         r = (r + 1) / 2;
      end
      return r;
   endfunction

endpackage

// File: rtl/mux_tree_level.sv
// One combinational 2:1 level of the mux tree: N lanes in, ceil(N/2) lanes out.
module mux_tree_level #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned N     = 2
) (
   input  logic                             sel,
   input  logic [N*WIDTH-1:0]               in_data,
   output logic [((N+1)/2)*WIDTH-1:0]       out_data
);

   localparam int unsigned N_OUT = (N + 1) / 2;

   // Pair lanes 2i/2i+1; an odd tail lane sees zero on its i1 side
   for (genvar i = 0; i < N_OUT; i++) begin : gen_lane
      if (2 * i + 1 < N) begin : gen_pair
         assign out_data[i*WIDTH +: WIDTH] = sel ? in_data[(2*i+1)*WIDTH +: WIDTH]
                                                 : in_data[(2*i)*WIDTH +: WIDTH];
      end else begin : gen_tail
         assign out_data[i*WIDTH +: WIDTH] = sel ? '0
                                                 : in_data[(2*i)*WIDTH +: WIDTH];
      end
   end

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N_IN:1 mux tree with valid/ready flow control and out-of-range flagging.
module mux_tree_pipe
   import mux_pkg::*;
#(
   parameter  int unsigned WIDTH     = 64,
   parameter  int unsigned N_IN      = 32,
   parameter  int unsigned REG_EVERY = 2,
   localparam int unsigned SEL_W     = clog2_min1(N_IN)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]      in_sel,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_err
);

   localparam int unsigned LEVELS = (N_IN > 1) ? clog2_ceil(N_IN) : 0;
   localparam int unsigned LAT    = num_stages(LEVELS, REG_EVERY);

   if (LEVELS == 0) begin : gen_single
      logic             q_valid;
      logic [WIDTH-1:0] q_data;
      logic             unused_sel;

      assign unused_sel = ^in_sel;
      assign in_ready   = !q_valid || out_ready;

      // Single output register carrying lane 0
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            q_valid <= 1'b0;
            q_data  <= '0;
         end else if (in_ready) begin
            q_valid <= in_valid;
            if (in_valid) begin
               q_data <= in_data[WIDTH-1:0];
            end
         end
      end

      assign out_valid = q_valid;
      assign out_data  = q_data;
      assign out_err   = 1'b0;
   end else begin : gen_tree
      localparam int unsigned BUS_W = N_IN * WIDTH;

      // Level j input bus; lanes beyond the level's lane count stay zero
      logic [BUS_W-1:0] lvl_data [0:LEVELS];
      logic [SEL_W-1:0] lvl_sel  [0:LEVELS];
      logic [LEVELS:0]  lvl_valid;
      logic [LEVELS:0]  lvl_err;
      logic [LAT:1]     st_valid;
      logic [LAT:1]     st_ready;
      logic             unused_tail;

      assign lvl_data[0]  = in_data;
      assign lvl_sel[0]   = in_sel;
      assign lvl_valid[0] = in_valid;
      assign lvl_err[0]   = (32'(in_sel) >= N_IN);

      // Stage k is ready when it or any stage downstream has room, or the sink takes a beat
      for (genvar s = 1; s <= LAT; s++) begin : gen_ready
         assign st_ready[s] = out_ready || !(&st_valid[LAT:s]);
      end

      for (genvar j = 0; j < LEVELS; j++) begin : gen_lvl
         localparam int unsigned N_CUR = lanes_at(N_IN, j);
         localparam int unsigned N_NXT = (N_CUR + 1) / 2;

         logic [BUS_W-1:0] mux_data;

         mux_tree_level #(
            .WIDTH (WIDTH),
            .N     (N_CUR)
         ) u_level (
            .sel      (lvl_sel[j][j]),
            .in_data  (lvl_data[j][N_CUR*WIDTH-1:0]),
            .out_data (mux_data[N_NXT*WIDTH-1:0])
         );

         assign mux_data[BUS_W-1:N_NXT*WIDTH] = '0;

         if (((j + 1) % REG_EVERY == 0) || (j == LEVELS - 1)) begin : gen_reg
            localparam int unsigned S = (j + REG_EVERY) / REG_EVERY;

            logic             q_valid;
            logic [BUS_W-1:0] q_data;
            logic [SEL_W-1:0] q_sel;
            logic             q_err;

            // Stage register: advance on ready, capture payload only with a valid beat
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  q_valid <= 1'b0;
                  q_data  <= '0;
                  q_sel   <= '0;
                  q_err   <= 1'b0;
               end else if (st_ready[S]) begin
                  q_valid <= lvl_valid[j];
                  if (lvl_valid[j]) begin
                     q_data <= mux_data;
                     q_sel  <= lvl_sel[j];
                     q_err  <= lvl_err[j];
                  end
               end
            end

            assign st_valid[S]    = q_valid;
            assign lvl_valid[j+1] = q_valid;
            assign lvl_data[j+1]  = q_data;
            assign lvl_sel[j+1]   = q_sel;
            assign lvl_err[j+1]   = q_err;
         end else begin : gen_wire
            assign lvl_valid[j+1] = lvl_valid[j];
            assign lvl_data[j+1]  = mux_data;
            assign lvl_sel[j+1]   = lvl_sel[j];
            assign lvl_err[j+1]   = lvl_err[j];
         end
      end

      assign unused_tail = ^{lvl_sel[LEVELS], lvl_data[LEVELS][BUS_W-1:WIDTH]};

      assign in_ready  = st_ready[1];
      assign out_valid = lvl_valid[LEVELS];
      assign out_data  = lvl_data[LEVELS][WIDTH-1:0];
      assign out_err   = lvl_err[LEVELS];
   end

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Bench for mux_tree_pipe: five parameter sets against a lane-index reference model.
`timescale 1ns/1ps
module tb_mux_tree_pipe;

   localparam int NDUT = 5;
   localparam int unsigned NI [NDUT] = '{32, 5, 1, 2, 64};
   localparam int unsigned WI [NDUT] = '{64, 8, 32, 64, 16};
   localparam int unsigned SW [NDUT] = '{5, 3, 1, 1, 6};
   localparam int unsigned LT [NDUT] = '{3, 2, 1, 1, 6};

   typedef struct {
      logic [63:0] d;
      logic        e;
      int          c;
   } beat_t;

   logic clk;
   logic rst_n;
   logic        iv    [NDUT];
   logic        ordy  [NDUT];
   logic [7:0]  sel_v [NDUT];
   logic        ir    [NDUT];
   logic        ov    [NDUT];
   logic        oe    [NDUT];
   logic [63:0] od    [NDUT];
   logic [63:0] lanes [NDUT][64];

   logic [2047:0] d0;
   logic [39:0]   d1;
   logic [31:0]   d2;
   logic [127:0]  d3;
   logic [1023:0] d4;
   logic [63:0]   o0;
   logic [7:0]    o1;
   logic [31:0]   o2;
   logic [63:0]   o3;
   logic [15:0]   o4;

   beat_t       sb [NDUT][$];
   int          cyc = 0;
   int          last_stall [NDUT];
   logic        pend   [NDUT];
   logic [63:0] held_d [NDUT];
   logic        held_e [NDUT];
   int          n_out  [NDUT];
   int          n_chk = 0;
   int          n_bad = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      od[0] = o0;
      od[1] = 64'(o1);
      od[2] = 64'(o2);
      od[3] = o3;
      od[4] = 64'(o4);
   end

   mux_tree_pipe #(.WIDTH(64), .N_IN(32), .REG_EVERY(2)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(d0),
      .in_sel(sel_v[0][4:0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(o0), .out_err(oe[0]));
   mux_tree_pipe #(.WIDTH(8), .N_IN(5), .REG_EVERY(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(d1),
      .in_sel(sel_v[1][2:0]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(o1), .out_err(oe[1]));
   mux_tree_pipe #(.WIDTH(32), .N_IN(1), .REG_EVERY(1)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(d2),
      .in_sel(sel_v[2][0:0]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(o2), .out_err(oe[2]));
   mux_tree_pipe #(.WIDTH(64), .N_IN(2), .REG_EVERY(4)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .in_data(d3),
      .in_sel(sel_v[3][0:0]), .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(o3), .out_err(oe[3]));
   mux_tree_pipe #(.WIDTH(16), .N_IN(64), .REG_EVERY(1)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[4]), .in_ready(ir[4]), .in_data(d4),
      .in_sel(sel_v[4][5:0]), .out_valid(ov[4]), .out_ready(ordy[4]), .out_data(o4), .out_err(oe[4]));

   // Count one comparison and report it when it disagrees
   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] wmask(input int unsigned w);
      return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
   endfunction

   // Reference: lane by index, zero and error beyond the last real lane
   function automatic logic [63:0] ref_data(input int i, input int unsigned s);
      if (NI[i] == 1) return lanes[i][0];
      if (s < NI[i]) return lanes[i][s];
      return 64'd0;
   endfunction

   function automatic logic ref_err(input int i, input int unsigned s);
      return (NI[i] > 1) && (s >= NI[i]);
   endfunction

   task automatic build_data();
      for (int l = 0; l < 32; l++) d0[l*64 +: 64] = lanes[0][l];
      for (int l = 0; l < 5; l++)  d1[l*8 +: 8]   = lanes[1][l][7:0];
      d2 = lanes[2][0][31:0];
      for (int l = 0; l < 2; l++)  d3[l*64 +: 64] = lanes[3][l];
      for (int l = 0; l < 64; l++) d4[l*16 +: 16] = lanes[4][l][15:0];
   endtask

   task automatic rand_lanes(input int first);
      for (int i = first; i < NDUT; i++)
         for (int l = 0; l < 64; l++)
            lanes[i][l] = {$urandom, $urandom} & wmask(WI[i]);
      build_data();
   endtask

   // In-flight beats vanish with reset
   always @(negedge rst_n) begin
      for (int i = 0; i < NDUT; i++) begin
         sb[i].delete();
         pend[i] = 1'b0;
      end
   end

   // Scoreboard: sample just after the falling edge, transfers happen on the next rising edge
   always @(negedge clk) begin
      beat_t b;
      #1;
      if (rst_n) begin
         for (int i = 0; i < NDUT; i++) begin
            if (pend[i]) begin
               check_eq($sformatf("d%0d_hold_valid", i), 64'(ov[i]), 64'd1);
               check_eq($sformatf("d%0d_hold_data", i), od[i], held_d[i]);
               check_eq($sformatf("d%0d_hold_err", i), 64'(oe[i]), 64'(held_e[i]));
            end
            if (!ordy[i]) last_stall[i] = cyc;
            if (ov[i] && ordy[i]) begin
               check_eq($sformatf("d%0d_beat_pending", i), 64'(sb[i].size() > 0), 64'd1);
               if (sb[i].size() > 0) begin
                  b = sb[i].pop_front();
                  check_eq($sformatf("d%0d_data", i), od[i], b.d);
                  check_eq($sformatf("d%0d_err", i), 64'(oe[i]), 64'(b.e));
                  if (b.c > last_stall[i])
                     check_eq($sformatf("d%0d_latency", i), 64'(cyc - b.c), 64'(LT[i]));
                  n_out[i]++;
               end
            end
            pend[i]   = ov[i] && !ordy[i];
            held_d[i] = od[i];
            held_e[i] = oe[i];
            if (iv[i] && ir[i]) begin
               b.d = ref_data(i, int'(sel_v[i]));
               b.e = ref_err(i, int'(sel_v[i]));
               b.c = cyc;
               sb[i].push_back(b);
            end
         end
      end
   end

   initial begin
      int sent;
      int k;
      int base;
      int unsigned sels1 [8];

      sels1 = '{4, 5, 6, 7, 0, 3, 2, 1};
      rst_n = 1'b0;
      for (int i = 0; i < NDUT; i++) begin
         iv[i] = 1'b1;
         ordy[i] = 1'b1;
         sel_v[i] = 8'd0;
         pend[i] = 1'b0;
         last_stall[i] = -1;
         n_out[i] = 0;
      end
      rand_lanes(1);
      for (int l = 0; l < 64; l++) lanes[0][l] = 64'hA5A5_0000_0000_0000 + 64'(l);
      build_data();

      // Reset held for three cycles with in_valid asserted
      for (int r = 0; r < 3; r++) begin
         @(negedge clk);
         #2;
         for (int i = 0; i < NDUT; i++) begin
            check_eq($sformatf("d%0d_rst_valid", i), 64'(ov[i]), 64'd0);
            check_eq($sformatf("d%0d_rst_data", i), od[i], 64'd0);
            check_eq($sformatf("d%0d_rst_err", i), 64'(oe[i]), 64'd0);
         end
      end
      for (int i = 0; i < NDUT; i++) iv[i] = 1'b0;
      rst_n = 1'b1;
      #1;
      for (int i = 0; i < NDUT; i++)
         check_eq($sformatf("d%0d_ready_after_rst", i), 64'(ir[i]), 64'd1);

      // Full-rate stream through the default configuration
      for (int s = 0; s < 32; s++) begin
         @(negedge clk);
         iv[0] = 1'b1;
         sel_v[0] = 8'(s);
      end
      @(negedge clk);
      iv[0] = 1'b0;
      repeat (6) @(negedge clk);
      check_eq("d0_stream_count", 64'(n_out[0]), 64'd32);

      // Backpressure: five stalled cycles in the middle of an 8-beat stream
      base = n_out[0];
      sent = 0;
      k = 0;
      while (sent < 8 && k < 100) begin
         @(negedge clk);
         iv[0] = 1'b1;
         sel_v[0] = 8'((sent * 5) % 32);
         ordy[0] = !(k >= 3 && k < 8);
         #2;
         if (k == 7) check_eq("d0_bp_in_ready", 64'(ir[0]), 64'd0);
         if (ir[0]) sent++;
         k++;
      end
      check_eq("d0_bp_sent", 64'(sent), 64'd8);
      @(negedge clk);
      iv[0] = 1'b0;
      ordy[0] = 1'b1;
      repeat (6) @(negedge clk);
      check_eq("d0_bp_count", 64'(n_out[0] - base), 64'd8);
      check_eq("d0_bp_empty", 64'(sb[0].size()), 64'd0);

      // Five-lane tree: last lane and the three unused select codes
      for (int s = 0; s < 8; s++) begin
         @(negedge clk);
         iv[1] = 1'b1;
         sel_v[1] = 8'(sels1[s]);
      end
      @(negedge clk);
      iv[1] = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("d1_dir_count", 64'(n_out[1]), 64'd8);

      // Reset pulse between edges with three beats parked in the pipe
      ordy[0] = 1'b0;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         iv[0] = 1'b1;
         sel_v[0] = 8'(s + 10);
      end
      @(negedge clk);
      iv[0] = 1'b0;
      #2;
      check_eq("d0_prerst_valid", 64'(ov[0]), 64'd1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("d0_midrst_valid", 64'(ov[0]), 64'd0);
      check_eq("d0_midrst_data", od[0], 64'd0);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      ordy[0] = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         #2;
         check_eq("d0_no_stale", 64'(ov[0]), 64'd0);
      end

      // Random traffic on every configuration
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         rand_lanes(0);
         for (int i = 0; i < NDUT; i++) begin
            iv[i]    = ($urandom_range(0, 3) != 0);
            ordy[i]  = ($urandom_range(0, 4) != 0);
            sel_v[i] = 8'($urandom_range(0, (1 << SW[i]) - 1));
         end
      end
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
         iv[i] = 1'b0;
         ordy[i] = 1'b1;
      end
      repeat (10) @(negedge clk);
      #2;
      for (int i = 0; i < NDUT; i++)
         check_eq($sformatf("d%0d_drained", i), 64'(sb[i].size()), 64'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
